edge_count_sequencer: RTL

//   Self-checking stimulus sequencer for edge-detect event counting.

---
 rtl/edge_count_sequencer.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/edge_count_sequencer.sv
// ---------------------------------------------------------------------------
// edge_count_sequencer
//   Steps a WIDTH-bit stimulus vector from 0 up to a latched last value,
//   holding each value for STEP_CYCLES clocks.  While the run is active it
//   counts rising edges of a masked view of the stimulus.  When the last
//   value has been held for its full dwell, the count is compared with the
//   latched expected value and a one-cycle done pulse is raised together
//   with the pass verdict.
//
//   Build option EDGE_ANY_BIT_EN:
//     defined   -> the edge source is |(stim & mask), i.e. the masked vector
//                  leaving the all-zero value.
//     undefined -> the edge source is stim[0] & mask[0] (default).
// ---------------------------------------------------------------------------
module edge_count_sequencer #(
    parameter int WIDTH       = 4,
    parameter int CNT_W       = 4,
    parameter int STEP_CYCLES = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] mask,
    input  logic [WIDTH-1:0] last_val,
    input  logic [CNT_W-1:0] expected,
    output logic [WIDTH-1:0] stim,
    output logic             edge_pulse,
    output logic [CNT_W-1:0] edge_count,
    output logic             busy,
    output logic             done,
    output logic             pass
);

    // Dwell counter only has to reach STEP_CYCLES-1.
    localparam int DW = (STEP_CYCLES > 2) ? $clog2(STEP_CYCLES) : 1;

    localparam logic [DW-1:0]    LAST_DWELL = DW'(STEP_CYCLES - 1);
    localparam logic [DW-1:0]    DWELL_ONE  = DW'(1'b1);
    localparam logic [WIDTH-1:0] STIM_ONE   = WIDTH'(1'b1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    // Selects which masked stimulus bits feed the edge source; the rest of
    // the datapath is identical in both builds.
`ifdef EDGE_ANY_BIT_EN
    localparam logic [WIDTH-1:0] SIG_SEL = {WIDTH{1'b1}};
`else
    localparam logic [WIDTH-1:0] SIG_SEL = WIDTH'(1'b1);
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] stim_q, stim_d;
    logic [DW-1:0]    dwell_q, dwell_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] last_q, last_d;
    logic [CNT_W-1:0] exp_q, exp_d;
    logic             prev_q, prev_d;
    logic [CNT_W-1:0] edge_count_q, edge_count_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;

    logic             sig_s;
    logic             edge_pulse_s;
    logic [CNT_W-1:0] count_next_s;

    // Edge source and rising-edge detect, both decoded from registers only.
    always_comb begin
        sig_s        = |(stim_q & mask_q & SIG_SEL);
        edge_pulse_s = (state_q == ST_RUN) & sig_s & ~prev_q;
    end

    // Saturating edge counter update (never wraps back to zero).
    always_comb begin
        count_next_s = edge_count_q;
        if (edge_pulse_s && (edge_count_q != CNT_MAX)) begin
            count_next_s = edge_count_q + CNT_ONE;
        end else begin
            count_next_s = edge_count_q;
        end
    end

    // Next-state and datapath decode for the IDLE/RUN/CHECK sequencer.
    always_comb begin
        state_d      = state_q;
        stim_d       = stim_q;
        dwell_d      = dwell_q;
        mask_d       = mask_q;
        last_d       = last_q;
        exp_d        = exp_q;
        prev_d       = prev_q;
        edge_count_d = edge_count_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        pass_d       = pass_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // Accept a run: capture the configuration and clear
                    // everything the run builds up.
                    state_d      = ST_RUN;
                    mask_d       = mask;
                    last_d       = last_val;
                    exp_d        = expected;
                    stim_d       = {WIDTH{1'b0}};
                    dwell_d      = {DW{1'b0}};
                    edge_count_d = {CNT_W{1'b0}};
                    prev_d       = 1'b0;
                    pass_d       = 1'b0;
                    busy_d       = 1'b1;
                end else begin
                    busy_d = 1'b0;
                end
            end

            ST_RUN: begin
                prev_d       = sig_s;
                edge_count_d = count_next_s;
                busy_d       = 1'b1;
                if (dwell_q == LAST_DWELL) begin
                    dwell_d = {DW{1'b0}};
                    if (stim_q == last_q) begin
                        // Final value fully held: stim stays put and the
                        // verdict uses the count including this cycle.
                        state_d = ST_CHECK;
                        done_d  = 1'b1;
                        pass_d  = (count_next_s == exp_q);
                    end else begin
                        stim_d = stim_q + STIM_ONE;
                    end
                end else begin
                    dwell_d = dwell_q + DWELL_ONE;
                end
            end

            ST_CHECK: begin
                // One-cycle verdict state; start is not looked at here, so a
                // held start re-arms from IDLE on the following cycle.
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers; async reset clears everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            stim_q       <= {WIDTH{1'b0}};
            dwell_q      <= {DW{1'b0}};
            mask_q       <= {WIDTH{1'b0}};
            last_q       <= {WIDTH{1'b0}};
            exp_q        <= {CNT_W{1'b0}};
            prev_q       <= 1'b0;
            edge_count_q <= {CNT_W{1'b0}};
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            stim_q       <= stim_d;
            dwell_q      <= dwell_d;
            mask_q       <= mask_d;
            last_q       <= last_d;
            exp_q        <= exp_d;
            prev_q       <= prev_d;
            edge_count_q <= edge_count_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
        end
    end

    assign stim       = stim_q;
    assign edge_pulse = edge_pulse_s;
    assign edge_count = edge_count_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;

endmodule
